// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared FSM states, access-size encoding and byte-enable helpers for memory_stage.
package memory_stage_pkg;
  typedef enum logic {IDLE, REQ} state_t;
  typedef enum logic {SZ_WORD, SZ_BYTE} size_t;
  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_BYTE0 = 4'b1000;
  // Big-endian: byte offset 0 lives in bits 31:24, so the lane mask walks right with the offset.
  function automatic logic [3:0] byte_enables(input size_t size, input logic [1:0] off);
    return size == SZ_BYTE ? BE_BYTE0 >> off : BE_WORD;
  endfunction
endpackage

// File: rtl/memory_stage_load_align.sv
// load_align: selects the addressed big-endian byte of a read word and sign/zero extends it.
//   rdata    - raw word from data memory
//   offset   - byte offset within the word (0 = bits 31:24)
//   byte_acc - 1 = byte load, 0 = word load (rdata passes through)
//   uns      - 1 = zero-extend the byte, 0 = sign-extend
//   data     - aligned writeback value
module load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic        byte_acc,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0] b;
  always_comb begin
    b = 8'(rdata >> {~offset, 3'b000});
    data = byte_acc ? {{24{b[7] & ~uns}}, b} : rdata;
  end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: data-memory access stage between execute and the register-file write port.
//   in_valid/in_ready            - execute handshake; ready only while idle
//   aluOut/rBOut/dmwe/rwe/rwd/.. - execute result and controls
//   dm_*                         - req/ack data-memory port, held stable until dm_ack
//   wb_*                         - one-cycle writeback packet
//   align_err/bus_err            - one-cycle pulses for dropped accesses
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] aluOut,
  input  logic [31:0] rBOut,
  input  logic        dmwe,
  input  logic        rwe,
  input  logic        rwd,
  input  logic [4:0]  rdst,
  input  logic        byte_acc,
  input  logic        uns,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic        wb_rwe,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        align_err,
  output logic        bus_err
);
  state_t state, state_n;
  size_t size_in, l_size;
  logic [TO_W-1:0] cnt;
  logic [4:0] l_rd;
  logic [1:0] l_off;
  logic l_rwe, l_uns;
  logic accept, mem_op, misalign, done, timeout, wb_alu, wb_load;
  logic [31:0] ld_data;
  always_comb begin
    size_in = byte_acc ? SZ_BYTE : SZ_WORD;
    accept = state == IDLE && in_valid;
    mem_op = dmwe || rwd;
    misalign = mem_op && size_in == SZ_WORD && aluOut[1:0] != 2'b00;
    done = state == REQ && dm_ack;
    // An ack on the final allowed cycle takes priority over the timeout.
    timeout = state == REQ && !dm_ack && cnt == TO_W'(ACK_TIMEOUT - 1);
    wb_alu = accept && !mem_op;
    wb_load = done && !dm_we;
    state_n = state == IDLE ? (accept && mem_op && !misalign ? REQ : IDLE)
                            : (done || timeout ? IDLE : REQ);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  load_align u_load_align (
    .rdata(dm_rdata),
    .offset(l_off),
    .byte_acc(l_size == SZ_BYTE),
    .uns(l_uns),
    .data(ld_data)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      in_ready <= 1'b1;
      dm_req <= 1'b0;
      dm_we <= 1'b0;
      dm_addr <= '0;
      dm_be <= '0;
      dm_wdata <= '0;
      wb_valid <= 1'b0;
      wb_rwe <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      align_err <= 1'b0;
      bus_err <= 1'b0;
      cnt <= '0;
      l_rd <= '0;
      l_rwe <= 1'b0;
      l_uns <= 1'b0;
      l_off <= '0;
      l_size <= SZ_WORD;
    end else begin
      in_ready <= state_n == IDLE;
      dm_req <= state_n == REQ;
      align_err <= accept && misalign;
      bus_err <= timeout;
      wb_valid <= wb_alu || wb_load;
      // r0 is hardwired, so writes to it are suppressed while the pulse still fires.
      wb_rwe <= wb_alu ? rwe && rdst != 5'd0 : wb_load && l_rwe && l_rd != 5'd0;
      cnt <= state == REQ && !dm_ack ? cnt + 1'b1 : '0;
      if (wb_alu) begin
        wb_rd <= rdst;
        wb_data <= aluOut;
      end
      if (wb_load) begin
        wb_rd <= l_rd;
        wb_data <= ld_data;
      end
      if (state == IDLE && state_n == REQ) begin
        l_rd <= rdst;
        l_rwe <= rwe;
        l_uns <= uns;
        l_off <= aluOut[1:0];
        l_size <= size_in;
        dm_we <= dmwe;
        dm_addr <= {aluOut[31:2], 2'b00};
        dm_be <= byte_enables(size_in, aluOut[1:0]);
        dm_wdata <= size_in == SZ_BYTE ? {4{rBOut[7:0]}} : rBOut;
      end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized self-checking bench for memory_stage against a behavioural model.
module tb_memory_stage;
  logic clock = 0, reset_n = 0, in_valid = 0, in_ready;
  logic [31:0] aluOut = 0, rBOut = 0, dm_rdata = 0, dm_addr, dm_wdata, wb_data;
  logic dmwe = 0, rwe = 0, rwd = 0, byte_acc = 0, uns = 0, dm_ack = 0;
  logic [4:0] rdst = 0, wb_rd;
  logic dm_req, dm_we, wb_valid, wb_rwe, align_err, bus_err;
  logic [3:0] dm_be;
  int total = 0, bad = 0;

  typedef struct {
    logic req, we, held, wb_valid, wb_rwe, req_after, ready_after, bus_err;
    logic [31:0] addr, wdata, wb_data;
    logic [3:0] be;
    logic [4:0] wb_rd;
  } obs_t;

  memory_stage #(.ACK_TIMEOUT(4), .TO_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluOut(aluOut), .rBOut(rBOut), .dmwe(dmwe), .rwe(rwe), .rwd(rwd), .rdst(rdst),
    .byte_acc(byte_acc), .uns(uns), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_rwe(wb_rwe), .wb_rd(wb_rd), .wb_data(wb_data),
    .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] off, input logic b, input logic u);
    int unsigned v;
    if (!b) return rdata;
    v = (rdata / (32'd1 << (8 * (3 - int'(off))))) % 256;
    if (!u && v >= 128) v = v + 32'hFFFF_FF00;
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] off, input logic b);
    return b ? 4'(1 << (3 - int'(off))) : 4'hF;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] alu, input logic [31:0] rb, input logic we, input logic rw, input logic wd,
                       input logic [4:0] rd, input logic b, input logic u);
    aluOut = alu; rBOut = rb; dmwe = we; rwe = rw; rwd = wd; rdst = rd; byte_acc = b; uns = u;
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  task automatic do_mem(input logic [31:0] alu, input logic [31:0] rb, input logic we, input logic rw, input logic wd,
                        input logic [4:0] rd, input logic b, input logic u, input int delay,
                        input logic [31:0] rdata, output obs_t o);
    issue(alu, rb, we, rw, wd, rd, b, u);
    o.req = dm_req; o.we = dm_we; o.addr = dm_addr; o.be = dm_be; o.wdata = dm_wdata;
    o.held = !in_ready && !wb_valid;
    for (int c = 1; c < delay; c++) begin
      tick();
      o.held = o.held & dm_req & !in_ready & !wb_valid & (dm_addr == o.addr) & (dm_be == o.be) & (dm_wdata == o.wdata);
    end
    dm_ack = 1; dm_rdata = rdata;
    tick();
    dm_ack = 0; dm_rdata = $urandom;
    o.wb_valid = wb_valid; o.wb_rwe = wb_rwe; o.wb_rd = wb_rd; o.wb_data = wb_data;
    o.req_after = dm_req; o.ready_after = in_ready; o.bus_err = bus_err;
  endtask

  task automatic test_reset();
    tick(); tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    total++; if ({dm_req, dm_we, wb_valid, wb_rwe, align_err, bus_err} !== 6'b0) begin bad++;
      $display("FAIL reset_flags got %b want 000000", {dm_req, dm_we, wb_valid, wb_rwe, align_err, bus_err}); end
    total++; if ({dm_addr, dm_wdata, wb_data, dm_be, wb_rd} !== '0) begin bad++;
      $display("FAIL reset_buses addr=%h wdata=%h wbdata=%h be=%b rd=%0d want all 0", dm_addr, dm_wdata, wb_data, dm_be, wb_rd); end
    @(negedge clock); reset_n = 1;
    tick();
  endtask

  task automatic test_alu_pass();
    aluOut = 32'h42; rBOut = 0; rwd = 0; dmwe = 0; rwe = 1; rdst = 5; byte_acc = 0; uns = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) in_valid = 0;
      total++; if (!(wb_valid === 1 && wb_data === 32'h42 && wb_rd === 5'd5 && wb_rwe === 1 && in_ready === 1)) begin bad++;
        $display("FAIL alu_pass[%0d] valid=%b data=%h rd=%0d rwe=%b ready=%b want 1 00000042 5 1 1", i, wb_valid, wb_data, wb_rd, wb_rwe, in_ready); end
    end
    tick();
    total++; if (wb_valid !== 0) begin bad++; $display("FAIL alu_idle_wb got %b want 0", wb_valid); end
  endtask

  task automatic test_word_load();
    obs_t o;
    do_mem(32'h100, $urandom, 0, 1, 1, 5'd7, 0, 0, 3, 32'hDEAD_BEEF, o);
    total++; if (!(o.req === 1 && o.we === 0 && o.addr === 32'h100 && o.be === 4'hF)) begin bad++;
      $display("FAIL wload_req req=%b we=%b addr=%h be=%b want 1 0 00000100 1111", o.req, o.we, o.addr, o.be); end
    total++; if (o.held !== 1) begin bad++; $display("FAIL wload_held got %b want 1", o.held); end
    total++; if (!(o.wb_valid === 1 && o.wb_data === 32'hDEAD_BEEF && o.wb_rd === 5'd7 && o.wb_rwe === 1)) begin bad++;
      $display("FAIL wload_wb valid=%b data=%h rd=%0d rwe=%b want 1 deadbeef 7 1", o.wb_valid, o.wb_data, o.wb_rd, o.wb_rwe); end
    total++; if (!(o.req_after === 0 && o.ready_after === 1)) begin bad++;
      $display("FAIL wload_done req=%b ready=%b want 0 1", o.req_after, o.ready_after); end
  endtask

  task automatic test_byte_loads();
    logic [31:0] addr[3] = '{32'h103, 32'h103, 32'h101};
    logic un[3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] want[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0022};
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      do_mem(addr[i], $urandom, 0, 1, 1, 5'd9, 1, un[i], $urandom_range(1, 4), 32'h1122_3380, o);
      total++; if (!(o.wb_valid === 1 && o.wb_data === want[i] && o.addr === 32'h100 && o.be === ref_be(addr[i][1:0], 1))) begin bad++;
        $display("FAIL byte_load[%0d] valid=%b data=%h addr=%h be=%b want 1 %h 00000100 %b", i, o.wb_valid, o.wb_data, o.addr, o.be, want[i], ref_be(addr[i][1:0], 1)); end
    end
  endtask

  task automatic test_byte_store();
    obs_t o;
    do_mem(32'h202, 32'h0000_00AB, 1, 0, 0, 5'd3, 1, 0, 2, $urandom, o);
    total++; if (!(o.req === 1 && o.we === 1 && o.be === 4'b0010 && o.wdata === 32'hABAB_ABAB && o.addr === 32'h200)) begin bad++;
      $display("FAIL byte_store req=%b we=%b be=%b wdata=%h addr=%h want 1 1 0010 abababab 00000200", o.req, o.we, o.be, o.wdata, o.addr); end
    total++; if (!(o.wb_valid === 0 && o.req_after === 0 && o.ready_after === 1)) begin bad++;
      $display("FAIL store_done wb=%b req=%b ready=%b want 0 0 1", o.wb_valid, o.req_after, o.ready_after); end
  endtask

  task automatic test_ack_at_limit();
    obs_t o;
    do_mem(32'h40, 0, 0, 1, 1, 5'd4, 0, 0, 4, 32'h1234_5678, o);
    total++; if (!(o.wb_valid === 1 && o.wb_data === 32'h1234_5678 && o.bus_err === 0 && o.held === 1)) begin bad++;
      $display("FAIL ack_at_limit wb=%b data=%h bus_err=%b held=%b want 1 12345678 0 1", o.wb_valid, o.wb_data, o.bus_err, o.held); end
  endtask

  task automatic test_align_err();
    issue(32'h101, 0, 0, 1, 1, 5'd6, 0, 0);
    total++; if (!(align_err === 1 && dm_req === 0 && wb_valid === 0 && in_ready === 1)) begin bad++;
      $display("FAIL align_pulse err=%b req=%b wb=%b ready=%b want 1 0 0 1", align_err, dm_req, wb_valid, in_ready); end
    tick();
    total++; if (!(align_err === 0 && dm_req === 0)) begin bad++; $display("FAIL align_clear err=%b req=%b want 0 0", align_err, dm_req); end
  endtask

  task automatic test_timeout();
    int n = 0;
    issue(32'h300, 0, 0, 1, 1, 5'd8, 0, 0);
    while (dm_req === 1 && n < 20) begin n++; tick(); end
    total++; if (n != 4) begin bad++; $display("FAIL timeout_len got %0d req cycles want 4", n); end
    total++; if (!(bus_err === 1 && wb_valid === 0 && in_ready === 1)) begin bad++;
      $display("FAIL timeout_err bus_err=%b wb=%b ready=%b want 1 0 1", bus_err, wb_valid, in_ready); end
    tick();
    total++; if (bus_err !== 0) begin bad++; $display("FAIL timeout_pulse got %b want 0", bus_err); end
  endtask

  task automatic test_idle_ack();
    dm_ack = 1; dm_rdata = 32'hFFFF_FFFF;
    tick();
    dm_ack = 0;
    tick();
    total++; if (!(wb_valid === 0 && dm_req === 0 && in_ready === 1 && bus_err === 0)) begin bad++;
      $display("FAIL idle_ack wb=%b req=%b ready=%b bus_err=%b want 0 0 1 0", wb_valid, dm_req, in_ready, bus_err); end
  endtask

  task automatic test_reset_mid_req();
    issue(32'h500, 0, 0, 1, 1, 5'd2, 0, 0);
    total++; if (dm_req !== 1) begin bad++; $display("FAIL rst_pre_req got %b want 1", dm_req); end
    #2 reset_n = 0;
    #1;
    total++; if (!(dm_req === 0 && in_ready === 1)) begin bad++; $display("FAIL rst_async req=%b ready=%b want 0 1", dm_req, in_ready); end
    @(negedge clock); reset_n = 1;
    tick();
    total++; if (!(wb_valid === 0 && bus_err === 0 && align_err === 0 && in_ready === 1 && dm_req === 0)) begin bad++;
      $display("FAIL rst_after wb=%b bus=%b align=%b ready=%b req=%b want 0 0 0 1 0", wb_valid, bus_err, align_err, in_ready, dm_req); end
  endtask

  task automatic test_zero_rd();
    obs_t o;
    do_mem(32'h80, 0, 0, 1, 1, 5'd0, 0, 0, 1, 32'hCAFE_F00D, o);
    total++; if (!(o.wb_valid === 1 && o.wb_rwe === 0 && o.wb_data === 32'hCAFE_F00D)) begin bad++;
      $display("FAIL zero_rd_load wb=%b rwe=%b data=%h want 1 0 cafef00d", o.wb_valid, o.wb_rwe, o.wb_data); end
    issue(32'h77, 0, 0, 1, 0, 5'd0, 0, 0);
    total++; if (!(wb_valid === 1 && wb_rwe === 0 && wb_data === 32'h77)) begin bad++;
      $display("FAIL zero_rd_alu wb=%b rwe=%b data=%h want 1 0 00000077", wb_valid, wb_rwe, wb_data); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [31:0] alu, rb, rdata, exp_wdata;
    logic [4:0] rd;
    logic b, u, rw;
    int kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      alu = $urandom; rb = $urandom; rdata = $urandom; rd = 5'($urandom_range(0, 31));
      b = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        issue(alu, rb, 0, rw, 0, rd, b, u);
        total++; if (!(wb_valid === 1 && wb_data === alu && wb_rd === rd && wb_rwe === (rw && rd != 0) && align_err === 0)) begin bad++;
          $display("FAIL rand_alu[%0d] wb=%b data=%h rd=%0d rwe=%b want 1 %h %0d %b", i, wb_valid, wb_data, wb_rd, wb_rwe, alu, rd, rw && rd != 0); end
      end else if (!b && alu[1:0] != 2'b00) begin
        issue(alu, rb, kind == 2, rw, kind == 1, rd, b, u);
        total++; if (!(align_err === 1 && dm_req === 0 && wb_valid === 0)) begin bad++;
          $display("FAIL rand_align[%0d] err=%b req=%b wb=%b want 1 0 0", i, align_err, dm_req, wb_valid); end
        tick();
      end else begin
        do_mem(alu, rb, kind == 2, rw, kind == 1, rd, b, u, $urandom_range(1, 4), rdata, o);
        exp_wdata = b ? rb[7:0] * 32'h0101_0101 : rb;
        total++; if (!(o.req === 1 && o.we === (kind == 2) && o.addr === (alu & 32'hFFFF_FFFC) && o.be === ref_be(alu[1:0], b) && o.wdata === exp_wdata && o.held === 1)) begin bad++;
          $display("FAIL rand_req[%0d] we=%b addr=%h be=%b wdata=%h held=%b want %b %h %b %h 1", i, o.we, o.addr, o.be, o.wdata, o.held,
                   kind == 2, alu & 32'hFFFF_FFFC, ref_be(alu[1:0], b), exp_wdata); end
        if (kind == 1) begin
          total++; if (!(o.wb_valid === 1 && o.wb_data === ref_load(rdata, alu[1:0], b, u) && o.wb_rd === rd && o.wb_rwe === (rw && rd != 0))) begin bad++;
            $display("FAIL rand_load[%0d] wb=%b data=%h rd=%0d rwe=%b want 1 %h %0d %b", i, o.wb_valid, o.wb_data, o.wb_rd, o.wb_rwe,
                     ref_load(rdata, alu[1:0], b, u), rd, rw && rd != 0); end
        end else begin
          total++; if (!(o.wb_valid === 0 && o.ready_after === 1)) begin bad++;
            $display("FAIL rand_store[%0d] wb=%b ready=%b want 0 1", i, o.wb_valid, o.ready_after); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_word_load();
    test_byte_loads();
    test_byte_store();
    test_ack_at_limit();
    test_align_err();
    test_timeout();
    test_idle_ack();
    test_reset_mid_req();
    test_zero_rd();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Consumer end of the execute-stage result interface: accepts aluOut/rBOut plus the dmwe/rwe/rwd controls and performs the data-memory access.
- Drives a req/ack handshake to data memory.
- Performs byte-lane selection for word/byte loads and stores (big-endian), with sign or zero extension.
- Emits a one-cycle writeback packet to the register file.
- Sits between execute and the register-file write port; stalls execute via in_ready while a memory transaction is outstanding.

Parameters:
ACK_TIMEOUT, 255, cycles dm_req may stay unacknowledged before the access is abandoned (must be ≥1, ≤ 2^TO_W−1).
TO_W, 8, width of the timeout counter.

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  execute result valid this cycle
in_ready  out  1  stage can accept (high only in IDLE)
aluOut  in  32  ALU result / effective address
rBOut  in  32  store data
dmwe  in  1  1 = store
rwe  in  1  register write enable
rwd  in  1  writeback select: 1 = memory data, 0 = aluOut
rdst  in  5  destination register number
byte_acc  in  1  1 = byte access (LB/LBU/SB), 0 = word
uns  in  1  1 = zero-extend byte load (LBU)
dm_req  out  1  memory request, held until dm_ack
dm_we  out  1  1 = write
dm_addr  out  32  word-aligned address ({aluOut[31:2],2'b00})
dm_be  out  4  byte enables, bit3 = bits 31:24
dm_wdata  out  32  write data
dm_ack  in  1  transaction complete; dm_rdata valid same cycle for reads
dm_rdata  in  32  read data
wb_valid  out  1  one-cycle writeback pulse
wb_rwe  out  1  write enable for the register file
wb_rd  out  5  destination register
wb_data  out  32  writeback data
align_err  out  1  one-cycle pulse: misaligned word access, dropped
bus_err  out  1  one-cycle pulse: dm_ack timeout, access dropped

Behaviour:
- All outputs are registers; reset value is 0 for every output except in_ready, which resets to 1. Reset clears the FSM to IDLE and the timeout counter to 0.
- Memory op: dmwe=1 or rwd=1. Non-memory op: everything else.
- FSM has two states, IDLE and REQ.
- IDLE: in_ready=1. On in_valid:
  - Non-memory op: next cycle wb_valid=1, wb_data=aluOut, wb_rd=rdst, wb_rwe=rwe. Stay IDLE; back-to-back acceptance allowed.
  - Memory op with byte_acc=0 and aluOut[1:0]≠0: next cycle align_err=1, no dm_req, no wb_valid. Stay IDLE.
  - Otherwise: latch rdst/rwe/rwd/byte_acc/uns/offset (aluOut[1:0]). Next cycle dm_req=1 with dm_we=dmwe, dm_addr, dm_be and dm_wdata valid. Go to REQ; in_ready=0.
- Byte enables and write data:
  - Word: dm_be=4'b1111, dm_wdata=rBOut.
  - Byte at offset k: dm_be=4'b1000>>k, dm_wdata={4{rBOut[7:0]}}.
- REQ: dm_req and the address/data/enable outputs are held stable until dm_ack.
  - On the dm_ack cycle, the next cycle has dm_req=0, in_ready=1, state IDLE.
  - Load completion: wb_valid=1, wb_rwe=latched rwe, wb_rd=latched rdst.
    - Word load: wb_data=dm_rdata.
    - Byte load: byte b=dm_rdata[31−8k -: 8]; wb_data is b sign-extended, or zero-extended when uns=1.
  - Store completion: no wb_valid.
- Timeout: the counter increments each REQ cycle without dm_ack. When it reaches ACK_TIMEOUT, the next cycle has dm_req=0, bus_err=1, no wb_valid, state IDLE. dm_ack arriving in the same cycle the count reaches ACK_TIMEOUT wins; the access completes normally and no bus_err is raised.
- wb_rd=0: wb_rwe is forced 0; wb_valid still pulses for loads and ALU ops.
- dm_ack while in IDLE is ignored.
- in_valid while in_ready=0 is ignored; execute must hold its outputs.
- Latency:
  - ALU result: 1 cycle.
  - Load: 1 + (cycles until dm_ack) + 1 to wb_valid.
  - Store: dm_req asserted 1 cycle after acceptance.
- Reset asserted mid-REQ: dm_req drops immediately (asynchronous); no writeback and no error pulse.

Decomposition:
- Shared package memory_stage_pkg: FSM state encoding (IDLE, REQ), byte-enable constants (BE_WORD=4'b1111, BE_BYTE0=4'b1000), access-size encoding.
- One natural sub-module, load_align: combinational byte select and sign/zero extension taking dm_rdata, offset, byte_acc, uns. It is reused by the writeback datapath.

Test Plan:
- ALU pass-through: in_valid with aluOut=0x0000_0042, rwd=0, rwe=1, rdst=5 on 3 consecutive cycles → wb_valid on each following cycle, wb_data=0x42, wb_rd=5, in_ready stays 1.
- Word load: aluOut=0x100, rwd=1, dm_ack after 3 cycles with dm_rdata=0xDEADBEEF → dm_addr=0x100, dm_be=1111, wb_data=0xDEADBEEF one cycle after ack, in_ready low throughout REQ.
- Byte loads: aluOut=0x103, dm_rdata=0x1122_3380 → LB gives wb_data=0xFFFF_FF80; LBU (uns=1) gives 0x0000_0080; offset 1 LB gives 0x0000_0022.
- Byte store: aluOut=0x202, dmwe=1, rBOut=0x0000_00AB → dm_we=1, dm_be=0010, dm_wdata=0xABAB_ABAB, dm_addr=0x200, no wb_valid after ack.
- Errors: word load at aluOut=0x101 → align_err pulse, dm_req never asserted. Load with ACK_TIMEOUT=4 and no ack → bus_err after 4 REQ cycles, dm_req deasserts, returns to IDLE.
- Reset/zero register: reset_n low during REQ → dm_req=0 immediately, in_ready=1 after release. Load with rdst=0 → wb_valid=1, wb_rwe=0.
